cfu_mac_initiator: RTL

Command-side initiator for the filter-MAC custom function unit. On a start pulse it walks a tap count, streams filter coefficients into the CFU's filter store, clears the CFU accumulator, then issues one multiply-accumulate command per tap with the matching activation and returns the final accumulated value. It sits between on-chip coefficient/activation buffers and the CFU's cmd/rsp port, standing in for the CPU in hardware-offload and self-test configurations.

---
 rtl/cfu_mac_initiator.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/cfu_mac_initiator.sv
// Command-side initiator for the filter-MAC CFU: loads n filter taps, clears the
// accumulator, issues n MAC commands and returns the final accumulated value.
module cfu_mac_initiator #(
   parameter int unsigned N_TAPS = 108,
   parameter int unsigned AW     = 7
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [AW-1:0] n_taps,
   output logic          busy,
   output logic          done,
   output logic [31:0]   result,
   output logic [AW-1:0] filt_rd_addr,
   input  logic [31:0]   filt_rd_data,
   output logic [AW-1:0] act_rd_addr,
   input  logic [7:0]    act_rd_data,
   output logic          cmd_valid,
   input  logic          cmd_ready,
   output logic [9:0]    cmd_payload_function_id,
   output logic [31:0]   cmd_payload_inputs_0,
   output logic [31:0]   cmd_payload_inputs_1,
   input  logic          rsp_valid,
   output logic          rsp_ready,
   input  logic [31:0]   rsp_payload_outputs_0
);

   typedef enum logic [2:0] {StIdle, StFetch, StSend, StWait, StDone} state_e;
   typedef enum logic [1:0] {PhLoad, PhClear, PhMac} phase_e;

   localparam logic [AW:0] NTapsW = (AW+1)'(N_TAPS);

   state_e        state_q, state_d;
   phase_e        phase_q, phase_d;
   logic [AW-1:0] i_q, i_d;
   logic [AW-1:0] n_last_q, n_last_d;
   logic          first_q, first_d;
   logic [9:0]    fid_q, fid_d;
   logic [31:0]   in0_q, in0_d;
   logic [31:0]   in1_q, in1_d;
   logic [31:0]   result_q, result_d;

   logic [AW:0]   n_clip;
   logic [9:0]    live_fid;
   logic [31:0]   live_in0;
   logic [31:0]   live_in1;
   logic          send_first;

   // Payload built from the current phase; buffer data is valid in the first SEND cycle only.
   always_comb begin
      live_fid = 10'd0;
      live_in0 = 32'd0;
      live_in1 = 32'd0;
      unique case (phase_q)
         PhLoad: begin
            live_fid = {7'd2, 3'd0};
            live_in0 = 32'(i_q);
            live_in1 = filt_rd_data;
         end
         PhClear: begin
            live_fid = {7'd1, 3'd0};
         end
         PhMac: begin
            live_in0 = {{24{act_rd_data[7]}}, act_rd_data};
            live_in1 = 32'(i_q);
         end
         default: ;
      endcase
   end

   // Next-state logic for the run sequencer, phase, tap index and held payload.
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      i_d      = i_q;
      n_last_d = n_last_q;
      first_d  = 1'b0;
      fid_d    = fid_q;
      in0_d    = in0_q;
      in1_d    = in1_q;
      result_d = result_q;
      n_clip   = ({1'b0, n_taps} > NTapsW) ? NTapsW : {1'b0, n_taps};

      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (n_taps == '0) begin
                  result_d = 32'd0;
                  state_d  = StDone;
               end else begin
                  n_last_d = n_clip[AW-1:0] - AW'(1);
                  phase_d  = PhLoad;
                  i_d      = '0;
                  state_d  = StFetch;
               end
            end
         end
         StFetch: begin
            first_d = 1'b1;
            state_d = StSend;
         end
         StSend: begin
            // Capture the live payload once so it stays stable under backpressure.
            if (first_q) begin
               fid_d = live_fid;
               in0_d = live_in0;
               in1_d = live_in1;
            end
            if (cmd_ready) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (rsp_valid) begin
               unique case (phase_q)
                  PhLoad: begin
                     if (i_q < n_last_q) begin
                        i_d     = i_q + AW'(1);
                        state_d = StFetch;
                     end else begin
                        phase_d = PhClear;
                        first_d = 1'b1;
                        state_d = StSend;
                     end
                  end
                  PhClear: begin
                     i_d     = '0;
                     phase_d = PhMac;
                     state_d = StFetch;
                  end
                  PhMac: begin
                     if (i_q < n_last_q) begin
                        i_d     = i_q + AW'(1);
                        state_d = StFetch;
                     end else begin
                        result_d = rsp_payload_outputs_0;
                        state_d  = StDone;
                     end
                  end
                  default: state_d = StIdle;
               endcase
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; async reset clears every output-visible register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         phase_q  <= PhLoad;
         i_q      <= '0;
         n_last_q <= '0;
         first_q  <= 1'b0;
         fid_q    <= 10'd0;
         in0_q    <= 32'd0;
         in1_q    <= 32'd0;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         i_q      <= i_d;
         n_last_q <= n_last_d;
         first_q  <= first_d;
         fid_q    <= fid_d;
         in0_q    <= in0_d;
         in1_q    <= in1_d;
         result_q <= result_d;
      end
   end

   // Outputs decoded from state; first SEND cycle forwards the live payload.
   always_comb begin
      send_first              = (state_q == StSend) && first_q;
      busy                    = (state_q != StIdle);
      done                    = (state_q == StDone);
      result                  = result_q;
      cmd_valid               = (state_q == StSend);
      rsp_ready               = (state_q == StWait);
      filt_rd_addr            = ((state_q == StFetch) && (phase_q == PhLoad)) ? i_q : '0;
      act_rd_addr             = ((state_q == StFetch) && (phase_q == PhMac)) ? i_q : '0;
      cmd_payload_function_id = send_first ? live_fid : fid_q;
      cmd_payload_inputs_0    = send_first ? live_in0 : in0_q;
      cmd_payload_inputs_1    = send_first ? live_in1 : in1_q;
   end

endmodule
